// File: rtl/seq_pkg.sv
// Shared types and constants for the LED sequencer slice.
package seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } seq_state_e;

  localparam int SEQ_TIMEOUT_CYCLES = 16;
  localparam int SEQ_SYNC_STAGES    = 2;

endpackage

// File: rtl/led_sequencer_if.sv
// Read handshake between the sequencer (master) and its read-only pattern memory (slave).
interface led_sequencer_if #(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_SIZE = 4
) ();

  logic [WORD_SIZE-1:0]    r_data;
  logic                    r_ready;
  logic [ADDRESS_SIZE-1:0] r_addr;
  logic                    r_en;

  modport master (output r_en, output r_addr, input r_data, input r_ready);
  modport slave  (input r_en, input r_addr, output r_data, output r_ready);

endinterface

// File: rtl/slow_tick_sync.sv
// Brings slow_clock into the clock domain and emits a one-cycle step pulse per rising edge.
module slow_tick_sync
  import seq_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic slow_in,
  output logic step
);

  logic [SEQ_SYNC_STAGES-1:0] sync_q, sync_d;
  logic                       prev_q, prev_d;
  logic                       step_q, step_d;

  // Registered edge detect keeps step glitch-free and three cycles behind slow_in.
  always_comb begin
    sync_d = {sync_q[SEQ_SYNC_STAGES-2:0], slow_in};
    prev_d = sync_q[SEQ_SYNC_STAGES-1];
    step_d = sync_q[SEQ_SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      step_q <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/led_sequencer.sv
// Steps through MEMORY_QTY memory words, one per slow_clock rise, showing each on sequence_out.
// Define SEQ_READ_TIMEOUT_EN to abort reads that see no r_ready within SEQ_TIMEOUT_CYCLES.
module led_sequencer
  import seq_pkg::*;
#(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int MEMORY_QTY   = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            slow_clock,
  led_sequencer_if.master mem,
  output logic [7:0]      sequence_out
);

  localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(MEMORY_QTY - 1);

  seq_state_e              state_q, state_d;
  logic                    r_en_q, r_en_d;
  logic                    pending_q, pending_d;
  logic                    first_q, first_d;
  logic [ADDRESS_SIZE-1:0] r_addr_q, r_addr_d, next_addr;
  logic [7:0]              seq_q, seq_d, word_ext;
  logic                    step;

  slow_tick_sync u_sync (
    .clock   (clock),
    .reset   (reset),
    .slow_in (slow_clock),
    .step    (step)
  );

  if (WORD_SIZE >= 8) begin : g_wide
    assign word_ext = mem.r_data[7:0];
  end else begin : g_narrow
    assign word_ext = {{(8 - WORD_SIZE){1'b0}}, mem.r_data};
  end

  assign next_addr = (r_addr_q == LAST_ADDR) ? '0 : r_addr_q + 1'b1;

`ifdef SEQ_READ_TIMEOUT_EN
  localparam int TO_W = $clog2(SEQ_TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timed_out;
  assign timed_out = (to_cnt_q == TO_W'(SEQ_TIMEOUT_CYCLES - 1));
`endif

  // first_q masks a stale r_ready left over from the previous access.
  always_comb begin
    state_d   = state_q;
    r_en_d    = r_en_q;
    pending_d = pending_q;
    first_d   = 1'b0;
    r_addr_d  = r_addr_q;
    seq_d     = seq_q;
`ifdef SEQ_READ_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (step || pending_q) begin
          state_d   = REQ;
          r_en_d    = 1'b1;
          pending_d = 1'b0;
          first_d   = 1'b1;
`ifdef SEQ_READ_TIMEOUT_EN
          to_cnt_d  = '0;
`endif
        end
      end
      REQ: begin
        if (step) pending_d = 1'b1;
        if (!first_q && mem.r_ready) begin
          seq_d    = word_ext;
          state_d  = IDLE;
          r_en_d   = 1'b0;
          r_addr_d = next_addr;
        end
`ifdef SEQ_READ_TIMEOUT_EN
        else if (timed_out) begin
          state_d  = IDLE;
          r_en_d   = 1'b0;
          r_addr_d = next_addr;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      r_en_q    <= 1'b0;
      pending_q <= 1'b0;
      first_q   <= 1'b0;
      r_addr_q  <= '0;
      seq_q     <= '0;
`ifdef SEQ_READ_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      r_en_q    <= r_en_d;
      pending_q <= pending_d;
      first_q   <= first_d;
      r_addr_q  <= r_addr_d;
      seq_q     <= seq_d;
`ifdef SEQ_READ_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  assign mem.r_en     = r_en_q;
  assign mem.r_addr   = r_addr_q;
  assign sequence_out = seq_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: directed slow_clock steps against a behavioural memory.
module tb_led_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       slow_clock = 1'b0;
  logic [7:0] sequence_out;

  led_sequencer_if #(.WORD_SIZE(8), .ADDRESS_SIZE(4)) mem_if ();

  led_sequencer #(.WORD_SIZE(8), .ADDRESS_SIZE(4), .MEMORY_QTY(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .slow_clock   (slow_clock),
    .mem          (mem_if.master),
    .sequence_out (sequence_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] seq;
    logic [3:0] addr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   done = 0;

  int   mem_delay = 1;
  int   data_mode = 0;
  bit   stale_mode = 0;
  int   req_cnt = 0;

  bit         rst_at_edge = 1'b1;
  bit         prev_en = 1'b0;
  logic [7:0] prev_seq = 8'h00;
  int         reads_done = 0;
  int         en_len = 0;
  int         last_en_len = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [7:0] s, input logic [3:0] a);
    exp_t e;
    e.seq  = s;
    e.addr = a;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int edges, input int period);
    for (int i = 0; i < edges; i++) begin
      slow_clock = 1'b1;
      repeat (period / 2) @(negedge clock);
      slow_clock = 1'b0;
      repeat (period - period / 2) @(negedge clock);
    end
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || mem_if.r_en) && n < budget) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("[TB] FAIL %s_drain: got %0d entries still pending want 0", name, sb.size());
    end
    repeat (40) @(negedge clock);
  endtask

  function automatic logic [7:0] modelData(input logic [3:0] a);
    if (data_mode == 0) return (a == 4'd0) ? 8'h5A : 8'h00;
    return {4'h0, a} + 8'h01;
  endfunction

  // Memory: drives r_ready/r_data on falling edges, optionally leaving a stale ready up.
  initial begin
    mem_if.r_ready = 1'b0;
    mem_if.r_data  = 8'hEE;
    forever begin
      @(negedge clock);
      if (mem_if.r_en) begin
        req_cnt++;
        if (stale_mode && req_cnt == 1) begin
          mem_if.r_ready = 1'b1;
          mem_if.r_data  = 8'hEE;
        end else if (req_cnt > mem_delay) begin
          mem_if.r_ready = 1'b1;
          mem_if.r_data  = modelData(mem_if.r_addr);
        end else begin
          mem_if.r_ready = 1'b0;
          mem_if.r_data  = 8'hEE;
        end
      end else begin
        req_cnt        = 0;
        mem_if.r_ready = stale_mode;
        mem_if.r_data  = 8'hEE;
      end
    end
  end

  always @(posedge clock) rst_at_edge = reset;

  // Monitor: each non-reset fall of r_en is a completed read to check against the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (mem_if.r_en) en_len++;
      if (prev_en && !mem_if.r_en) begin
        last_en_len = en_len;
        en_len = 0;
        if (!rst_at_edge) begin
          reads_done++;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_read: got seq 0x%0h addr %0d want no read", sequence_out, mem_if.r_addr);
          end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("read_seq", {24'h0, sequence_out}, {24'h0, e.seq});
            checkOutput("read_addr", {28'h0, mem_if.r_addr}, {28'h0, e.addr});
          end
        end
      end else if (!rst_at_edge && sequence_out !== prev_seq) begin
        total++;
        bad++;
        $display("[TB] FAIL seq_hold: got 0x%0h want 0x%0h", sequence_out, prev_seq);
      end
      if (!mem_if.r_en) en_len = 0;
      prev_en  = mem_if.r_en;
      prev_seq = sequence_out;
    end
  end

  initial begin
    bit seen;
    int base;
    int n;

    // Reset for one cycle, then confirm the sequencer stays idle without a step.
    @(negedge clock);
    reset = 1'b0;
    checkOutput("rst_r_en", {31'h0, mem_if.r_en}, 32'h0);
    checkOutput("rst_r_addr", {28'h0, mem_if.r_addr}, 32'h0);
    checkOutput("rst_seq", {24'h0, sequence_out}, 32'h0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (mem_if.r_en) seen = 1'b1;
    end
    checkOutput("idle_no_en", {31'h0, seen}, 32'h0);

    $display("[TB] single step, delay 2");
    data_mode = 0;
    mem_delay = 2;
    pushExp(8'h5A, 4'd1);
    applyStimulus(1, 10);
    waitDrain("single", 200);
    checkOutput("single_en_len_ge3", {31'h0, (last_en_len >= 3)}, 32'h1);
    checkOutput("single_en_low", {31'h0, mem_if.r_en}, 32'h0);

    $display("[TB] full wrap, 17 steps");
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    data_mode = 1;
    mem_delay = 1;
    for (int i = 0; i < 17; i++) pushExp(8'((i % 16) + 1), 4'((i + 1) % 16));
    applyStimulus(17, 10);
    waitDrain("wrap", 300);
    checkOutput("wrap_addr", {28'h0, mem_if.r_addr}, 32'h1);

    $display("[TB] stale ready");
    stale_mode = 1'b1;
    mem_delay = 3;
    repeat (10) @(negedge clock);
    checkOutput("stale_idle_en", {31'h0, mem_if.r_en}, 32'h0);
    checkOutput("stale_idle_seq", {24'h0, sequence_out}, 32'h01);
    pushExp(8'h02, 4'd2);
    applyStimulus(1, 10);
    waitDrain("stale", 200);
    stale_mode = 1'b0;

    $display("[TB] queued step, delay 20");
    mem_delay = 20;
    base = reads_done;
    pushExp(8'h03, 4'd3);
    pushExp(8'h04, 4'd4);
    applyStimulus(3, 10);
    waitDrain("queued", 300);
    checkOutput("queued_reads", reads_done - base, 32'd2);
    checkOutput("queued_addr", {28'h0, mem_if.r_addr}, 32'h4);

    $display("[TB] reset mid-read");
    mem_delay = 50;
    applyStimulus(1, 10);
    n = 0;
    while (!mem_if.r_en && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput("midrd_en_high", {31'h0, mem_if.r_en}, 32'h1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("midrd_r_en", {31'h0, mem_if.r_en}, 32'h0);
    checkOutput("midrd_r_addr", {28'h0, mem_if.r_addr}, 32'h0);
    checkOutput("midrd_seq", {24'h0, sequence_out}, 32'h0);
    repeat (20) @(negedge clock);
    checkOutput("midrd_stays_idle", {31'h0, mem_if.r_en}, 32'h0);
    checkOutput("sb_empty", sb.size(), 32'd0);

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clock);
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL watchdog: got no completion after 20000 cycles want completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

endmodule
